mips_issue_queue: RTL and testbench

Instruction issue buffer that sits directly upstream of the 4-stage MIPS execution core. It accepts `{instruction, output_reg}` pairs from a host over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues at most one pair per cycle to the core's `in_valid/instruction/output_reg` inputs. It also tracks in-flight instructions and counts issued and failed instructions from the core's returned status.

---
 rtl/mips_issue_queue.sv | 118 +++++++++++
 tb/tb_mips_issue_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_issue_queue.sv
// Issue buffer ahead of the 4-stage MIPS core: FIFO of {instruction, output_reg},
// one registered issue per cycle, plus in-flight tracking and issue/fail statistics.
module mips_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [31:0]              s_instruction,
    input  logic [19:0]              s_output_reg,
    output logic                     s_ready,
    input  logic                     issue_en,
    input  logic                     flush,
    output logic                     in_valid,
    output logic [31:0]              instruction,
    output logic [19:0]              output_reg,
    input  logic                     core_out_valid,
    input  logic                     core_instruction_fail,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2:0]               inflight,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]    r_mem_ins [DEPTH];
    logic [19:0]    r_mem_reg [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [LW-1:0]  r_level;
    logic           r_in_valid;
    logic [31:0]    r_instr;
    logic [19:0]    r_oreg;
    logic [2:0]     r_inflight;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_fail;

    logic w_push;
    logic w_pop;
    logic w_ret;
    logic w_fail;

    assign s_ready = (r_level != FULL) && !flush;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = issue_en && (r_level != '0) && !flush;
    // Returns with nothing in flight are ignored so the count never wraps.
    assign w_ret   = core_out_valid && (r_inflight != 3'd0);
    assign w_fail  = core_out_valid && core_instruction_fail;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ins[r_tail] <= s_instruction;
            r_mem_reg[r_tail] <= s_output_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_level    <= '0;
            r_in_valid <= 1'b0;
            r_instr    <= '0;
            r_oreg     <= '0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_level    <= '0;
            r_in_valid <= 1'b0;
            r_instr    <= '0;
            r_oreg     <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) begin
                r_head     <= r_head + 1'b1;
                r_in_valid <= 1'b1;
                r_instr    <= r_mem_ins[r_head];
                r_oreg     <= r_mem_reg[r_head];
            end else begin
                r_in_valid <= 1'b0;
                r_instr    <= '0;
                r_oreg     <= '0;
            end
            if (w_push && !w_pop) r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    // Flush leaves these alone: issued work still completes in the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_issued   <= '0;
            r_fail     <= '0;
        end else begin
            if (w_pop && !w_ret) r_inflight <= r_inflight + 3'd1;
            else if (!w_pop && w_ret) r_inflight <= r_inflight - 3'd1;
            if (w_pop && r_issued != CNT_MAX) r_issued <= r_issued + 1'b1;
            if (w_fail && r_fail != CNT_MAX) r_fail <= r_fail + 1'b1;
        end
    end

    assign in_valid    = r_in_valid;
    assign instruction = r_instr;
    assign output_reg  = r_oreg;
    assign level       = r_level;
    assign inflight    = r_inflight;
    assign issued_cnt  = r_issued;
    assign fail_cnt    = r_fail;
    assign idle        = (r_level == '0) && (r_inflight == 3'd0);

endmodule

// File: tb/tb_mips_issue_queue.sv
// Bench for mips_issue_queue: directed steps plus random traffic checked against
// a queue-based reference model with a 3-cycle-return core model.
module tb_mips_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [31:0] s_instruction;
    logic [19:0] s_output_reg;
    logic        s_ready;
    logic        issue_en;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic [19:0] output_reg;
    logic        core_out_valid;
    logic        core_instruction_fail;
    logic [3:0]  level;
    logic [2:0]  inflight;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic        idle;

    mips_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_instruction(s_instruction),
        .s_output_reg(s_output_reg), .s_ready(s_ready),
        .issue_en(issue_en), .flush(flush),
        .in_valid(in_valid), .instruction(instruction),
        .output_reg(output_reg),
        .core_out_valid(core_out_valid),
        .core_instruction_fail(core_instruction_fail),
        .level(level), .inflight(inflight),
        .issued_cnt(issued_cnt), .fail_cnt(fail_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [51:0] q[$];
    logic        m_inv;
    logic [31:0] m_ins;
    logic [19:0] m_or;
    int          m_inf;
    int          m_iss;
    int          m_fail;
    logic [3:0]  h;
    bit          auto_core;
    int          peak;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_inv = 0; m_ins = 0; m_or = 0;
        m_inf = 0; m_iss = 0; m_fail = 0;
        h = 0;
    endtask

    task automatic checkall(input string ph);
        chk({ph, ".in_valid"}, 32'(in_valid), 32'(m_inv));
        chk({ph, ".instruction"}, instruction, m_ins);
        chk({ph, ".output_reg"}, 32'(output_reg), 32'(m_or));
        chk({ph, ".level"}, 32'(level), 32'(q.size()));
        chk({ph, ".inflight"}, 32'(inflight), 32'(m_inf));
        chk({ph, ".issued_cnt"}, 32'(issued_cnt), 32'(m_iss));
        chk({ph, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
        chk({ph, ".idle"}, 32'(idle), 32'(q.size() == 0 && m_inf == 0));
    endtask

    task automatic step(input string ph);
        bit ready;
        bit pop;
        logic [51:0] e;
        if (auto_core) begin
            core_out_valid = h[3];
            core_instruction_fail = h[3] ? 1'($urandom_range(1)) : 1'b0;
        end
        #1;
        ready = (q.size() < DEPTH) && !flush;
        chk({ph, ".s_ready"}, 32'(s_ready), 32'(ready));
        pop = !flush && issue_en && q.size() > 0;
        if (core_out_valid && core_instruction_fail && m_fail < CMAX) m_fail++;
        if (core_out_valid && m_inf > 0) m_inf--;
        if (pop) begin
            e = q.pop_front();
            m_inv = 1; m_ins = e[51:20]; m_or = e[19:0];
            m_inf++;
            if (m_iss < CMAX) m_iss++;
        end else begin
            m_inv = 0; m_ins = 0; m_or = 0;
        end
        if (flush) q.delete();
        else if (s_valid && ready) q.push_back({s_instruction, s_output_reg});
        h = {h[2:0], m_inv};
        @(posedge clk);
        #1;
        checkall(ph);
        if (32'(inflight) > peak) peak = int'(inflight);
    endtask

    initial begin
        rst_n = 0; s_valid = 0; s_instruction = 0; s_output_reg = 0;
        issue_en = 0; flush = 0; core_out_valid = 0;
        core_instruction_fail = 0; auto_core = 1; peak = 0;
        m_reset();
        #12;
        chk("reset.s_ready", 32'(s_ready), 32'd1);
        checkall("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // Three entries held, then issued in order
        for (int k = 0; k < 3; k++) begin
            s_valid = 1;
            s_instruction = 32'h2000_0000 | k;
            s_output_reg = 20'h84210 + 20'(k);
            step("push3");
        end
        s_valid = 0;
        chk("push3.level", 32'(level), 32'd3);
        issue_en = 1;
        for (int k = 0; k < 4; k++) step("issue3");
        chk("issue3.issued", 32'(issued_cnt), 32'd3);

        // Fill to full, reject ninth, then push while popping
        issue_en = 0;
        for (int k = 0; k < 9; k++) begin
            s_valid = 1;
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("fill");
        end
        chk("fill.level", 32'(level), 32'd8);
        issue_en = 1;
        for (int k = 0; k < 3; k++) begin
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("fullpp");
        end
        s_valid = 0;
        for (int k = 0; k < 14; k++) step("drain");

        // Continuous stream of 20
        peak = 0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1;
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("stream");
        end
        s_valid = 0;
        for (int k = 0; k < 8; k++) step("stream_tail");
        chk("stream.peak", 32'(peak), 32'd4);
        chk("stream.idle", 32'(idle), 32'd1);

        // Flush with entries queued and two in flight
        issue_en = 0;
        for (int k = 0; k < 7; k++) begin
            s_valid = 1;
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("fl_fill");
        end
        s_valid = 0;
        issue_en = 1;
        step("fl_iss");
        step("fl_iss");
        flush = 1;
        step("flush");
        flush = 0;
        chk("flush.level", 32'(level), 32'd0);
        for (int k = 0; k < 5; k++) step("fl_drain");
        chk("flush.inflight", 32'(inflight), 32'd0);

        // Spurious return with nothing in flight
        auto_core = 0;
        core_out_valid = 1;
        core_instruction_fail = 1;
        step("spurious");
        core_out_valid = 0;
        core_instruction_fail = 0;
        auto_core = 1;
        step("spurious2");

        // Random traffic, including counter saturation
        for (int k = 0; k < 300; k++) begin
            s_valid = ($urandom_range(9) < 7);
            issue_en = ($urandom_range(9) < 8);
            flush = ($urandom_range(19) == 0);
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("rand");
        end
        flush = 0;
        chk("rand.issued_sat", 32'(issued_cnt), 32'(CMAX));

        // Asynchronous reset mid-burst
        s_valid = 1;
        issue_en = 1;
        for (int k = 0; k < 5; k++) begin
            s_instruction = $urandom;
            s_output_reg = 20'($urandom);
            step("burst");
        end
        #2;
        rst_n = 0;
        core_out_valid = 0;
        #1;
        m_reset();
        checkall("async_rst");
        #2;
        rst_n = 1;
        s_valid = 1;
        s_instruction = 32'hDEAD_BEEF;
        s_output_reg = 20'hABCDE;
        step("lat_push");
        s_valid = 0;
        chk("lat.n1", 32'(in_valid), 32'd0);
        step("lat_pop");
        chk("lat.n2", 32'(in_valid), 32'd1);
        chk("lat.ins", instruction, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) step("lat_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
